// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - handshake and serial-line bundle for piso_serializer
// Purpose: groups the parallel word handshake, the serial outputs and the busy
//          status of the serializer into one port.
// Signals: data_i/valid_i (word offered by upstream), ready_o (word can be taken),
//          x_o/bit_valid_o/last_o (serial bit, bit qualifier, last-bit marker),
//          busy_o (word shifting or pending).
// Modports: master = upstream word source / line observer, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             x_o;
  logic             bit_valid_o;
  logic             last_o;
  logic             busy_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  x_o,
    input  bit_valid_o,
    input  last_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output x_o,
    output bit_valid_o,
    output last_o,
    output busy_o
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with one-word holding buffer
// Purpose: accepts WIDTH-bit words over a valid/ready handshake and sends them one
//          bit per clock, MSB or LSB first, streaming back-to-back words with no gap.
// Ports:   clk   - clock, rising edge
//          reset - asynchronous, active-high reset
//          bus   - piso_serializer_if slave: data_i/valid_i/ready_o word handshake,
//                  x_o/bit_valid_o/last_o serial line, busy_o status
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              reset,
  piso_serializer_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             on_last;
  logic [WIDTH-1:0] shreg_shifted;

  // ready is simply "holding register free", so an accept needs only that.
  assign accept  = bus.valid_i && !hold_v_q;
  assign on_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // Move the next bit toward the output end, zero-filling behind it.
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.data_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!on_last) begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + CNT_ONE;
          if (accept) begin
            hold_d   = bus.data_i;
            hold_v_d = 1'b1;
          end
        end else if (hold_v_q) begin
          // Pending word follows immediately; ready is low so no accept here.
          shreg_d  = hold_q;
          hold_v_d = 1'b0;
          cnt_d    = '0;
        end else if (accept) begin
          // Word arriving on the last-bit edge bypasses the holding register.
          shreg_d = bus.data_i;
          cnt_d   = '0;
        end else begin
          // cnt stays at its last value; it only reloads on a new word.
          shreg_d = shreg_shifted;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registers only
  always_comb begin
    bus.ready_o     = !hold_v_q;
    bus.bit_valid_o = (state_q == SHIFT);
    bus.x_o         = 1'b0;
    if (state_q == SHIFT) begin
      bus.x_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end
    bus.last_o      = on_last;
    bus.busy_o      = (state_q == SHIFT) || hold_v_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (4-bit MSB-first and 8-bit LSB-first)
module tb_piso_serializer;

  logic clk;
  logic reset;

  int n_checks;
  int n_errors;

  piso_serializer_if #(.WIDTH(4)) bus4 ();
  piso_serializer_if #(.WIDTH(8)) bus8 ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  always #5 clk = ~clk;

  // 4-bit receiver shifting the line in every clock
  logic [3:0] rx_sr;
  always @(posedge clk) rx_sr <= {rx_sr[2:0], bus4.x_o};

  typedef struct {
    logic       b;
    logic       l;
    logic [3:0] w;
  } bit_t;

  // Observed outputs as {ready, x, bit_valid, last, busy}
  function automatic logic [4:0] outs4();
    return {bus4.ready_o, bus4.x_o, bus4.bit_valid_o, bus4.last_o, bus4.busy_o};
  endfunction

  function automatic logic [4:0] outs8();
    return {bus8.ready_o, bus8.x_o, bus8.bit_valid_o, bus8.last_o, bus8.busy_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus4.valid_i = 1'b0;
    bus4.data_i  = '0;
    bus8.valid_i = 1'b0;
    bus8.data_i  = '0;
    step();
    step();
    n_checks++;
    if (outs4() !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_w4: got %b expected 10000", outs4());
    end
    n_checks++;
    if (outs8() !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_w8: got %b expected 10000", outs8());
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (outs4() !== 5'b10000) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %b expected 10000", outs4());
    end
  endtask

  task automatic test_single_word();
    logic [3:0] w;
    logic [4:0] exp;
    w = 4'b1011;
    bus4.valid_i = 1'b1;
    bus4.data_i  = w;
    step();
    bus4.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, w[3-i], 1'b1, (i == 3), 1'b1};
      n_checks++;
      if (outs4() !== exp) begin
        n_errors++;
        $display("FAIL single_bit%0d: got %b expected %b", i, outs4(), exp);
      end
      step();
    end
    n_checks++;
    if (outs4() !== 5'b10000) begin
      n_errors++;
      $display("FAIL single_idle: got %b expected 10000", outs4());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  words [3];
    logic [11:0] bits, lst, rdy;
    logic [4:0]  exp;
    int          idx;
    bit          xfer;
    words = '{4'hA, 4'h3, 4'hF};
    bits  = 12'b1010_0011_1111;
    lst   = 12'b0001_0001_0001;
    rdy   = 12'b1000_1000_1111;
    idx   = 0;
    bus4.valid_i = 1'b1;
    bus4.data_i  = words[0];
    for (int i = 0; i < 12; i++) begin
      xfer = bus4.valid_i && bus4.ready_o;
      step();
      if (xfer) begin
        idx++;
        if (idx < 3) bus4.data_i = words[idx];
        else bus4.valid_i = 1'b0;
      end
      exp = {rdy[11-i], bits[11-i], 1'b1, lst[11-i], 1'b1};
      n_checks++;
      if (outs4() !== exp) begin
        n_errors++;
        $display("FAIL b2b_bit%0d: got %b expected %b", i, outs4(), exp);
      end
    end
    step();
    n_checks++;
    if (outs4() !== 5'b10000) begin
      n_errors++;
      $display("FAIL b2b_idle: got %b expected 10000", outs4());
    end
  endtask

  task automatic test_last_edge_accept();
    logic [7:0] bits, lst;
    logic [4:0] exp;
    bits = 8'b0110_1001;
    lst  = 8'b0001_0001;
    bus4.valid_i = 1'b1;
    bus4.data_i  = 4'h6;
    step();
    bus4.valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, bits[7-i], 1'b1, lst[7-i], 1'b1};
      n_checks++;
      if (outs4() !== exp) begin
        n_errors++;
        $display("FAIL last_edge_bit%0d: got %b expected %b", i, outs4(), exp);
      end
      if (i == 3) begin
        bus4.valid_i = 1'b1;
        bus4.data_i  = 4'h9;
      end
      step();
      if (i == 3) bus4.valid_i = 1'b0;
    end
    n_checks++;
    if (outs4() !== 5'b10000) begin
      n_errors++;
      $display("FAIL last_edge_idle: got %b expected 10000", outs4());
    end
  endtask

  task automatic test_lsb_first_w8();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'h81;
    bus8.valid_i = 1'b1;
    bus8.data_i  = w;
    step();
    bus8.valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, w[i], 1'b1, (i == 7), 1'b1};
      n_checks++;
      if (outs8() !== exp) begin
        n_errors++;
        $display("FAIL lsb_w8_bit%0d: got %b expected %b", i, outs8(), exp);
      end
      step();
    end
    n_checks++;
    if (outs8() !== 5'b10000) begin
      n_errors++;
      $display("FAIL lsb_w8_idle: got %b expected 10000", outs8());
    end
  endtask

  task automatic test_reset_mid_word();
    bus4.valid_i = 1'b1;
    bus4.data_i  = 4'hC;
    step();
    bus4.data_i  = 4'h5;
    step();
    bus4.valid_i = 1'b0;
    // second bit of 4'hC on the line, 4'h5 pending
    n_checks++;
    if (outs4() !== 5'b01101) begin
      n_errors++;
      $display("FAIL mid_word_before_reset: got %b expected 01101", outs4());
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs4() !== 5'b10000) begin
      n_errors++;
      $display("FAIL async_reset: got %b expected 10000", outs4());
    end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (outs4() !== 5'b10000) begin
        n_errors++;
        $display("FAIL no_resend_cycle%0d: got %b expected 10000", i, outs4());
      end
    end
  endtask

  task automatic test_random_loopback();
    bit_t       q[$];
    bit_t       e;
    logic [4:0] exp;
    logic [3:0] rx_exp;
    bit         rx_pend;
    bit         xfer;
    int         sent, done, cyc;
    rx_pend = 1'b0;
    rx_exp  = '0;
    sent    = 0;
    done    = 0;
    cyc     = 0;
    bus4.valid_i = 1'b0;
    while ((done < 1000 || rx_pend) && cyc < 20000) begin
      // a word is pending in hold exactly when more than one word of bits is queued
      if (q.size() > 0) exp = {(q.size() <= 4), q[0].b, 1'b1, q[0].l, 1'b1};
      else exp = 5'b10000;
      n_checks++;
      if (outs4() !== exp) begin
        n_errors++;
        $display("FAIL random_line_cycle%0d: got %b expected %b", cyc, outs4(), exp);
      end
      if (rx_pend) begin
        n_checks++;
        if (rx_sr !== rx_exp) begin
          n_errors++;
          $display("FAIL loopback_word%0d: got %h expected %h", done, rx_sr, rx_exp);
        end
        rx_pend = 1'b0;
      end
      if (q.size() > 0) begin
        if (q[0].l) begin
          rx_pend = 1'b1;
          rx_exp  = q[0].w;
          done++;
        end
        void'(q.pop_front());
      end
      if (!bus4.valid_i && sent < 1000 && $urandom_range(0, 3) != 0) begin
        bus4.valid_i = 1'b1;
        bus4.data_i  = 4'($urandom);
      end
      xfer = bus4.valid_i && exp[4];
      if (xfer) begin
        for (int b = 3; b >= 0; b--) begin
          e.b = bus4.data_i[b];
          e.l = (b == 0);
          e.w = bus4.data_i;
          q.push_back(e);
        end
        sent++;
      end
      step();
      cyc++;
      if (xfer) bus4.valid_i = 1'b0;
    end
    n_checks++;
    if (done < 1000) begin
      n_errors++;
      $display("FAIL random_timeout: got %0d words expected 1000", done);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    clk          = 1'b0;
    reset        = 1'b1;
    bus4.valid_i = 1'b0;
    bus4.data_i  = '0;
    bus8.valid_i = 1'b0;
    bus8.data_i  = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_last_edge_accept();
    test_lsb_first_w8();
    test_reset_mid_word();
    test_random_loopback();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that is the sending end of the 4-bit serial shift-register receiver link. It accepts parallel words through a valid/ready handshake, buffers one pending word, and drives one bit per clock on a serial line with a bit-valid qualifier and a last-bit marker. With the default MSB-first order, a receiver that shifts `{sr[2:0], x}` holds the original word after the final bit. Back-to-back words stream with no idle cycles between them.

## Interface
- `WIDTH`, default 4: word width in bits; legal values are ≥ 2.
- `MSB_FIRST`, default 1: 1 transmits bit `WIDTH-1` first; 0 transmits bit 0 first.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `data_i` input `WIDTH`: parallel word to transmit.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: block can accept a word. A transfer occurs at a rising edge where `valid_i && ready_o`.
- `x_o` output 1: serial data out.
- `bit_valid_o` output 1: `x_o` carries a data bit this cycle.
- `last_o` output 1: the current bit is the final bit of its word.
- `busy_o` output 1: a word is being shifted, or a word is pending in the holding register.

## Operation
- State: FSM {IDLE, SHIFT}.
  - Shift register `shreg[WIDTH-1:0]`.
  - Bit counter `cnt`, `$clog2(WIDTH)` bits, counting 0..`WIDTH-1`.
  - One-entry holding register `hold`, with flag `hold_v`.
- Reset values:
  - FSM = IDLE; `shreg`, `cnt`, `hold` = 0; `hold_v` = 0.
  - Outputs: `ready_o`=1, `x_o`=0, `bit_valid_o`=0, `last_o`=0, `busy_o`=0.
- Output decode, combinational from registers only:
  - `ready_o` = !`hold_v`.
  - `bit_valid_o` = (FSM==SHIFT).
  - `x_o` = `shreg[WIDTH-1]` when `MSB_FIRST`, else `shreg[0]`; forced to 0 in IDLE.
  - `last_o` = SHIFT && `cnt`==`WIDTH-1`.
  - `busy_o` = SHIFT || `hold_v`.
- IDLE:
  - On accept: `shreg`←`data_i`, `cnt`←0, go to SHIFT.
- SHIFT, not on the last bit:
  - Shift `shreg` by one toward the output end, filling with 0. `cnt`++.
  - An accept in this state loads `hold`←`data_i` and sets `hold_v`=1.
- SHIFT, on the last bit (`last_o`=1):
  - If `hold_v`: `shreg`←`hold`, `hold_v`←0, `cnt`←0, stay in SHIFT. No accept is possible, since `ready_o`=0.
  - Else if an accept occurs at this edge: `shreg`←`data_i` directly, `cnt`←0, stay in SHIFT. `hold` is not used.
  - Else: go to IDLE.
- Counter wrap: `cnt` never exceeds `WIDTH-1`; it reloads to 0 only on a new word.
- Reset mid-word: the in-flight word and the pending word are both discarded. Outputs take their reset values immediately (asynchronous).
- `data_i` and `valid_i` are ignored whenever `ready_o`=0. The upstream holds `valid_i` until the transfer occurs.

## Timing
- Latency: word accepted at edge k → first bit on `x_o` (with `bit_valid_o`=1) in the cycle after edge k. The last bit is in the cycle after edge k+`WIDTH`-1, with `last_o`=1.
- Throughput: one word per `WIDTH` cycles sustained, with zero gap cycles when the next word is accepted or held before the last-bit edge.
- `ready_o` falls the cycle after a word is captured into `hold`. It rises the cycle after `hold` is transferred to `shreg`.
- Combinational paths: none from inputs to outputs.
- Receiver alignment: a receiver sampling `x_o` on the same clock holds the full word after the edge that ends the `last_o` cycle.

## Test plan
- Reset, then accept 4'b1011 with `MSB_FIRST`=1 → `x_o` = 1,0,1,1 over 4 cycles with `bit_valid_o`=1. `last_o`=1 on the 4th bit only. Then IDLE: `x_o`=0, `busy_o`=0.
- Continuous `valid_i` with words 4'hA, 4'h3, 4'hF → 12 consecutive bits 1010_0011_1111 with no gap. `ready_o`=0 while `hold` is full. `last_o` is high on bits 4, 8 and 12.
- Accept coinciding with the last-bit edge while `hold` is empty (4'h6, then 4'h9 offered on the `last_o` cycle) → 0110 followed immediately by 1001, and `hold_v` stays 0.
- `MSB_FIRST`=0, `WIDTH`=8, word 8'h81 → bits 1,0,0,0,0,0,0,1 (LSB first). `last_o` is high on the 8th bit.
- Assert `reset` during bit 2 of 4'hC with 4'h5 pending → outputs go to reset values immediately. After release there is no output until a new accept; 4'h5 is never sent.
- Loopback into the 4-bit receiver using random words → receiver `sr_o` equals each word in the cycle after that word's `last_o` cycle, for 1000 words.
